dec_scan: RTL and testbench



---
 rtl/dec_scan_if.sv | 23 ++
 rtl/dec_scan.sv | 130 +++++++++++++
 tb/tb_dec_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dec_scan_if.sv
// rtl/dec_scan_if.sv - select/output bundle for dec_scan.
// Carries the skip mask only when DEC_SCAN_SKIP_EN is defined.
interface dec_scan_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             enb_;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [OUT_W-1:0] o;
  logic [SEL_W-1:0] cur_sel;
  logic             wrap;
`ifdef DEC_SCAN_SKIP_EN
  logic [OUT_W-1:0] skip;

  modport master (output enb_, mode, sel, skip, input o, cur_sel, wrap);
  modport slave  (input enb_, mode, sel, skip, output o, cur_sel, wrap);
`else
  modport master (output enb_, mode, sel, input o, cur_sel, wrap);
  modport slave  (input enb_, mode, sel, output o, cur_sel, wrap);
`endif
endinterface

// File: rtl/dec_scan.sv
// rtl/dec_scan.sv - registered one-hot decoder with auto-scan and per-channel dwell.
// Define DEC_SCAN_SKIP_EN to add a skip mask that excludes channels from the scan.
module dec_scan #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  dec_scan_if.slave  bus
);
  localparam int OUT_W = 2 ** SEL_W;
  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [OUT_W-1:0] o_q, o_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot = OUT_W'(1) << idx;
  endfunction

`ifdef DEC_SCAN_SKIP_EN
  logic [SEL_W-1:0] entry_idx, adv_idx, e_idx, a_idx;
  logic             adv_pass, any_open;

  // Loops run from farthest to nearest so the last hit is the nearest open channel.
  always_comb begin
    any_open  = ~&bus.skip;
    entry_idx = bus.sel;
    adv_idx   = cur_q;
    adv_pass  = 1'b0;
    e_idx     = bus.sel;
    a_idx     = cur_q;
    for (int i = OUT_W - 1; i >= 0; i--) begin
      e_idx = bus.sel + SEL_W'(i);
      if (!bus.skip[e_idx]) entry_idx = e_idx;
    end
    for (int i = OUT_W; i >= 1; i--) begin
      a_idx = cur_q + SEL_W'(i);
      if (!bus.skip[a_idx]) begin
        adv_idx  = a_idx;
        adv_pass = (32'(cur_q) + 32'(i)) >= 32'(OUT_W);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      o_q     <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      o_q     <= o_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    o_d     = '0;
    wrap_d  = 1'b0;
    cnt_d   = '0;

    if (bus.enb_)      state_d = IDLE;
    else if (!bus.mode) state_d = DIRECT;
    else               state_d = SCAN;

    case (state_d)
      DIRECT: begin
        cur_d = bus.sel;
        o_d   = onehot(bus.sel);
      end
      SCAN: begin
        if (state_q != SCAN) begin
          // Start channel is captured here once; sel is ignored until the next entry.
`ifdef DEC_SCAN_SKIP_EN
          if (any_open) begin
            cur_d = entry_idx;
            o_d   = onehot(entry_idx);
          end
`else
          cur_d = bus.sel;
          o_d   = onehot(bus.sel);
`endif
        end else begin
`ifdef DEC_SCAN_SKIP_EN
          if (any_open) begin
            if (cnt_q == DWELL_M1) begin
              cur_d  = adv_idx;
              wrap_d = adv_pass;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
            o_d = onehot(cur_d);
          end
`else
          if (cnt_q == DWELL_M1) begin
            cur_d  = cur_q + 1'b1;
            wrap_d = &cur_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          o_d = onehot(cur_d);
`endif
        end
      end
      default: ;
    endcase
  end

  assign bus.o       = o_q;
  assign bus.cur_sel = cur_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_dec_scan.sv
// tb/tb_dec_scan.sv - directed and randomized checks of dec_scan against a cycle-count model.
module tb_dec_scan;
  localparam int SEL_W = 3;
  localparam int DWELL = 2;
  localparam int OUT_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec_scan_if #(.SEL_W(SEL_W)) bus ();

  dec_scan #(.SEL_W(SEL_W), .DWELL(DWELL), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 direct, 2 scan; scan channel derived from cycles since entry.
  int         ph = 0;
  int         start = 0;
  int         k = 0;
  logic [7:0] m_o = '0;
  logic [2:0] m_cur = '0;
  logic       m_wrap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic m, input logic [2:0] s);
    rst      = r;
    bus.enb_ = e;
    bus.mode = m;
    bus.sel  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic r, input logic e, input logic m, input logic [2:0] s);
    int ch;
    m_wrap = 1'b0;
    if (r) begin
      ph = 0; m_o = '0; m_cur = '0;
    end else if (e) begin
      ph = 0; m_o = '0;
    end else if (!m) begin
      ph = 1; m_cur = s; m_o = 8'(1) << s;
    end else if (ph != 2) begin
      ph = 2; start = int'(s); k = 0; m_cur = s; m_o = 8'(1) << s;
    end else begin
      k++;
      ch = (start + k / DWELL) % OUT_W;
      m_cur = 3'(ch);
      m_o = 8'(1) << ch;
      m_wrap = (k % DWELL == 0) && (ch == 0);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m, input logic [2:0] s);
    apply(r, e, m, s);
    model(r, e, m, s);
    chk("o", 32'(bus.o), 32'(m_o));
    chk("cur_sel", 32'(bus.cur_sel), 32'(m_cur));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
  endtask

  initial begin
    logic       re, ee, me;
    logic [2:0] se;
    logic [31:0] one;
    one = 32'h1;
`ifdef DEC_SCAN_SKIP_EN
    bus.skip = '0;
`endif
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd5);
    chk("disable_o", 32'(bus.o), 32'h0);

    for (int s = 0; s < 8; s++) begin
      step(0, 0, 0, 3'(s));
      chk("direct_lit", 32'(bus.o), one << s);
    end

    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 3'd6);
      if (i == 4) chk("scan_wrap_lit", 32'(bus.wrap), 32'h1);
      if (i == 6) chk("scan_after_wrap", 32'(bus.o), 32'h02);
    end

    for (int i = 0; i < 3; i++) step(0, 1, 1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3'd3);
      if (i < 2) chk("restart_lit", 32'(bus.o), 32'h08);
    end

    step(0, 0, 0, 3'd1);
    chk("mode_switch_lit", 32'(bus.o), 32'h02);

    for (int i = 0; i < 3; i++) step(0, 0, 1, 3'd4);
    step(1, 0, 1, 3'd4);
    chk("rst_mid_scan", 32'(bus.cur_sel), 32'h0);

    re = 1'b0; ee = 1'b0; me = 1'b1; se = '0;
    for (int i = 0; i < 400; i++) begin
      re = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0)  ee = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) me = ($urandom_range(0, 2) != 0);
      se = 3'($urandom);
      step(re, ee, me, se);
    end

`ifdef DEC_SCAN_SKIP_EN
    begin
      logic [2:0] exp_ch [9];
      exp_ch = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
      apply(1, 1, 0, 0);
      bus.skip = 8'hF0;
      apply(0, 1, 0, 0);
      for (int i = 0; i < 9; i++) begin
        apply(0, 0, 1, 3'd2);
        chk("skip_cur", 32'(bus.cur_sel), 32'(exp_ch[i]));
        chk("skip_wrap", 32'(bus.wrap), (i == 4) ? 32'h1 : 32'h0);
      end
      bus.skip = 8'hFF;
      apply(0, 0, 1, 3'd2);
      chk("skip_all_o", 32'(bus.o), 32'h0);
      bus.skip = 8'h00;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
